// File: rtl/fp_seq_ctrl.sv
// Issue/writeback sequencer for a fixed-latency FP unit.
// Optional macro FP_SEQ_DIV_EN enables fdiv (funct5D=00011).
module fp_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       FPD,
  input  logic [4:0] funct5D,
  input  logic [4:0] rdD,
  input  logic       FlushE,
  output logic       FPStartE,
  output logic [1:0] FPOpE,
  output logic       FPBusy,
  output logic       StallD,
  output logic       FPWriteW,
  output logic [4:0] FPRdW,
  output logic       FPIllegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] lat;
  logic       sup;
  logic       req;
  logic       in_busy;
  logic       issue;

  // Decode op support and its counter preload (latency minus two).
  always_comb begin
    sup = 1'b0;
    lat = 4'd0;
    unique case (funct5D)
      5'b00000: begin sup = 1'b1; lat = 4'd1; end
      5'b00001: begin sup = 1'b1; lat = 4'd1; end
      5'b00010: begin sup = 1'b1; lat = 4'd2; end
`ifdef FP_SEQ_DIV_EN
      5'b00011: begin sup = 1'b1; lat = 4'd10; end
`endif
      default: begin sup = 1'b0; lat = 4'd0; end
    endcase
  end

  // Next-state and handshake outputs; reset masks all pulses.
  always_comb begin
    state_nx  = state;
    req       = FPD & ~FlushE & ~reset;
    in_busy   = (state == BUSY);
    issue     = req & sup & ~in_busy;
    FPStartE  = issue;
    FPIllegal = req & ~sup & ~in_busy;
    StallD    = req & in_busy;
    FPWriteW  = ~reset & (state == WB);
    FPBusy    = (state != IDLE);
    unique case (state)
      IDLE: if (issue) state_nx = BUSY;
      BUSY: if (cnt == 4'd0) state_nx = WB;
      WB:   state_nx = issue ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latency counter and latched op/rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      FPOpE <= 2'b00;
      FPRdW <= 5'd0;
    end else begin
      state <= state_nx;
      if (issue) begin
        cnt   <= lat;
        FPOpE <= funct5D[1:0];
        FPRdW <= rdD;
      end else if (in_busy && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Bench for fp_seq_ctrl: timeline reference model plus
// directed literal scenarios and randomized traffic.
module tb_fp_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       FPD;
  logic [4:0] funct5D;
  logic [4:0] rdD;
  logic       FlushE;
  logic       FPStartE;
  logic [1:0] FPOpE;
  logic       FPBusy;
  logic       StallD;
  logic       FPWriteW;
  logic [4:0] FPRdW;
  logic       FPIllegal;

  fp_seq_ctrl dut (
    .clk(clk), .reset(reset), .FPD(FPD),
    .funct5D(funct5D), .rdD(rdD), .FlushE(FlushE),
    .FPStartE(FPStartE), .FPOpE(FPOpE), .FPBusy(FPBusy),
    .StallD(StallD), .FPWriteW(FPWriteW), .FPRdW(FPRdW),
    .FPIllegal(FPIllegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: an op is in flight until its absolute writeback cycle.
  int       t = 0;
  bit       m_fl = 0;
  int       m_wb = 0;
  bit [4:0] m_rd = 0;
  bit [1:0] m_op = 0;

  function automatic bit op_ok(input bit [4:0] f);
`ifdef FP_SEQ_DIV_EN
    return f <= 5'd3;
`else
    return f <= 5'd2;
`endif
  endfunction

  function automatic int op_lat(input bit [4:0] f);
    if (f == 5'd2) return 4;
    if (f == 5'd3) return 12;
    return 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               nm, t, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against model, advance model.
  task automatic cyc(input bit r, input bit d, input bit [4:0] f,
                     input bit [4:0] rd, input bit fl);
    bit busy, wb, live, iss;
    @(negedge clk);
    reset = r; FPD = d; funct5D = f; rdD = rd; FlushE = fl;
    #1;
    wb   = m_fl && (t == m_wb);
    busy = m_fl && (t < m_wb);
    live = !r && d && !fl;
    iss  = live && op_ok(f) && !busy;
    chk("start", int'(FPStartE), int'(iss));
    chk("stall", int'(StallD), int'(live && busy));
    chk("illegal", int'(FPIllegal), int'(live && !op_ok(f) && !busy));
    chk("write", int'(FPWriteW), int'(!r && wb));
    chk("busy", int'(FPBusy), int'(m_fl));
    chk("rd", int'(FPRdW), int'(m_rd));
    chk("op", int'(FPOpE), int'(m_op));
    @(posedge clk);
    if (r) begin
      m_fl = 0; m_rd = 0; m_op = 0;
    end else if (iss) begin
      m_fl = 1; m_wb = t + op_lat(f); m_rd = rd; m_op = f[1:0];
    end else if (wb) begin
      m_fl = 0;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    reset = 1; FPD = 0; funct5D = 0; rdD = 0; FlushE = 0;
    @(posedge clk);
    cyc(1, 1, 5'd0, 5'd9, 0);
    chk("rst_start_lit", int'(FPStartE), 0);
    idle(1);
    chk("rst_busy_lit", int'(FPBusy), 0);
    chk("rst_rd_lit", int'(FPRdW), 0);
    chk("rst_op_lit", int'(FPOpE), 0);

    // fadd rd5: start at 0, write at 3, idle at 4
    cyc(0, 1, 5'd0, 5'd5, 0);
    chk("fadd_start_lit", int'(FPStartE), 1);
    idle(2);
    cyc(0, 0, 5'd0, 5'd0, 0);
    chk("fadd_wr_lit", int'(FPWriteW), 1);
    chk("fadd_rd_lit", int'(FPRdW), 5);
    cyc(0, 0, 5'd0, 5'd0, 0);
    chk("fadd_idle_lit", int'(FPBusy), 0);

    // fmul rd7 then held fadd rd8
    cyc(0, 1, 5'd2, 5'd7, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 5'd0, 5'd8, 0);
      chk("mul_stall_lit", int'(StallD), 1);
    end
    cyc(0, 1, 5'd0, 5'd8, 0);
    chk("mul_wb_start_lit", int'(FPStartE), 1);
    chk("mul_wb_wr_lit", int'(FPWriteW), 1);
    chk("mul_wb_rd_lit", int'(FPRdW), 7);
    idle(2);
    cyc(0, 0, 5'd0, 5'd0, 0);
    chk("add2_wr_lit", int'(FPWriteW), 1);
    chk("add2_rd_lit", int'(FPRdW), 8);
    idle(1);

    // fdiv rd3
    cyc(0, 1, 5'd3, 5'd3, 0);
`ifdef FP_SEQ_DIV_EN
    chk("div_start_lit", int'(FPStartE), 1);
    idle(11);
    cyc(0, 0, 5'd0, 5'd0, 0);
    chk("div_wr_lit", int'(FPWriteW), 1);
    chk("div_rd_lit", int'(FPRdW), 3);
`else
    chk("div_ill_lit", int'(FPIllegal), 1);
    chk("div_nostart_lit", int'(FPStartE), 0);
    cyc(0, 0, 5'd0, 5'd0, 0);
    chk("div_ill_pulse_lit", int'(FPIllegal), 0);
    chk("div_nobusy_lit", int'(FPBusy), 0);
`endif
    idle(1);

    // flush blocks issue
    cyc(0, 1, 5'd0, 5'd4, 1);
    chk("flush_start_lit", int'(FPStartE), 0);
    chk("flush_stall_lit", int'(StallD), 0);
    idle(1);
    chk("flush_idle_lit", int'(FPBusy), 0);

    // reset mid-op abandons writeback
`ifdef FP_SEQ_DIV_EN
    cyc(0, 1, 5'd3, 5'd6, 0);
    idle(4);
`else
    cyc(0, 1, 5'd2, 5'd6, 0);
    idle(1);
`endif
    chk("mid_busy_lit", int'(FPBusy), 1);
    cyc(1, 0, 5'd0, 5'd0, 0);
    cyc(0, 0, 5'd0, 5'd0, 0);
    chk("mid_rst_busy_lit", int'(FPBusy), 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 5'd0, 5'd0, 0);
      chk("mid_rst_nowr_lit", int'(FPWriteW), 0);
    end

    // unsupported funct5D
    cyc(0, 1, 5'd31, 5'd2, 0);
    chk("bad_ill_lit", int'(FPIllegal), 1);
    chk("bad_start_lit", int'(FPStartE), 0);
    chk("bad_stall_lit", int'(StallD), 0);
    idle(1);
    chk("bad_busy_lit", int'(FPBusy), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit       r, d, fl;
      bit [4:0] f;
      r  = ($urandom_range(0, 99) < 2);
      d  = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 10);
      f  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 3))
                                      : 5'($urandom);
      cyc(r, d, f, 5'($urandom), fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
